// File: rtl/onebyn_pkg.sv
// Shared widths, constants and FSM encoding for the 1/N reciprocal table generator.
package onebyn_pkg;

  localparam int unsigned ONEBYN_NBITS    = 8;
  localparam int unsigned ONEBYN_QBITS    = 17;
  localparam int unsigned ONEBYN_DIVIDEND = 65536;
  localparam logic [ONEBYN_QBITS-1:0] ONEBYN_ZERO_VAL = 17'h1FFFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    WRITE,
    DONE
  } onebyn_state_e;

endpackage

// File: rtl/onebyn_table_gen_if.sv
// Control and table-RAM write port of the reciprocal table generator.
interface onebyn_table_gen_if;
  import onebyn_pkg::*;

  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    wr_en;
  logic [ONEBYN_NBITS-1:0] wr_addr;
  logic [ONEBYN_QBITS-1:0] wr_data;
  logic                    wr_ready;

  modport master (
    input  start, wr_ready,
    output busy, done, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, wr_ready,
    input  busy, done, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/recip_div_seq.sv
// Iterative restoring divider: ONEBYN_DIVIDEND / divisor, one quotient bit per cycle, MSB first.
// valid is high on the cycle whose closing edge produces the last quotient bit.
module recip_div_seq
  import onebyn_pkg::*;
#(
  parameter int unsigned NBITS = ONEBYN_NBITS,
  parameter int unsigned QBITS = ONEBYN_QBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [NBITS-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [QBITS-1:0] quotient
);

  localparam int unsigned CNTW  = $clog2(QBITS);
  localparam int unsigned RBITS = NBITS + 1;

  logic [RBITS-1:0] rem_q;
  logic [QBITS-1:0] shift_q;
  logic [NBITS-1:0] div_q;
  logic [CNTW-1:0]  cnt_q;
  logic             busy_q;
  logic             valid_q;

  logic [RBITS:0]   trial_c;
  logic             fits_c;
  logic [RBITS-1:0] rem_nx_c;
  logic [QBITS-1:0] quot_nx_c;
  logic             last_c;

  // Dividend bits leave the top of shift_q while quotient bits enter at the bottom.
  always_comb begin
    trial_c   = {rem_q, shift_q[QBITS-1]};
    fits_c    = (trial_c >= (RBITS+1)'(div_q));
    rem_nx_c  = fits_c ? RBITS'(trial_c - (RBITS+1)'(div_q)) : RBITS'(trial_c);
    quot_nx_c = {shift_q[QBITS-2:0], fits_c};
    last_c    = (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q   <= '0;
      shift_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (load) begin
      rem_q   <= '0;
      shift_q <= QBITS'(ONEBYN_DIVIDEND);
      div_q   <= divisor;
      cnt_q   <= CNTW'(QBITS - 1);
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
    end else if (busy_q) begin
      rem_q   <= rem_nx_c;
      // Division by zero saturates so every entry still takes the full QBITS steps.
      shift_q <= (last_c && (div_q == '0)) ? {QBITS{1'b1}} : quot_nx_c;
      cnt_q   <= cnt_q - CNTW'(1);
      busy_q  <= !last_c;
      valid_q <= (cnt_q == CNTW'(1));
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign quotient = shift_q;

endmodule

// File: rtl/onebyn_table_gen.sv
// Generates the floor(65536/N) reciprocal table at run time and streams it into the table RAM.
module onebyn_table_gen
  import onebyn_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  onebyn_table_gen_if.master bus
);

  localparam int unsigned NBITS = ONEBYN_NBITS;
  localparam int unsigned QBITS = ONEBYN_QBITS;
  localparam logic [NBITS-1:0] IDX_LAST = '1;

  onebyn_state_e    state_q, state_d;
  logic [NBITS-1:0] idx_q, idx_d;
  logic             div_load_c;
  logic             div_busy;
  logic             div_valid;
  logic [QBITS-1:0] div_quot;

  logic             busy_q;
  logic             done_q;
  logic             wr_en_q;
  logic [NBITS-1:0] wr_addr_q;

  recip_div_seq #(
    .NBITS (NBITS),
    .QBITS (QBITS)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load_c),
    .divisor  (idx_q),
    .busy     (div_busy),
    .valid    (div_valid),
    .quotient (div_quot)
  );

  // Next-state logic; the divider for the next entry is loaded only after the write is accepted.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    div_load_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        div_load_c = 1'b1;
        state_d    = DIV;
      end
      DIV: begin
        if (div_valid) state_d = WRITE;
      end
      WRITE: begin
        if (bus.wr_ready && !div_busy) begin
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + NBITS'(1);
            state_d = LOAD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      wr_en_q   <= (state_d == WRITE);
      wr_addr_q <= idx_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = div_quot;

endmodule

// File: tb/tb_onebyn_table_gen.sv
// Self-checking bench for onebyn_table_gen against a floor(65536/N) reference table.
module tb_onebyn_table_gen;
  import onebyn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  onebyn_table_gen_if bus ();

  onebyn_table_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // wr_ready driver: 0 = always ready, 1 = stall stall_addr for 5 cycles, 2 = random 50%.
  int ready_mode = 0;
  int stall_addr = 10;
  int run_len    = 0;
  always @(posedge clk) begin
    #1;
    if (!bus.wr_en) run_len = 0;
    case (ready_mode)
      1: begin
        if (bus.wr_en && bus.wr_addr == 8'(stall_addr) && run_len < 5) begin
          bus.wr_ready = 1'b0;
          run_len++;
        end else begin
          bus.wr_ready = 1'b1;
        end
      end
      2:       bus.wr_ready = 1'($urandom_range(0, 1));
      default: bus.wr_ready = 1'b1;
    endcase
  end

  // Passive monitor, cumulative logs; tests look at slices past a snapshot index.
  int          wr_addr_q[$];
  logic [16:0] wr_data_q[$];
  int          rise_cyc_q[$];
  int          done_cyc_q[$];
  int          stall_addr_q[$];
  logic [16:0] stall_data_q[$];
  int          stab_err = 0;
  logic        prev_wr_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_addr  = '0;
  logic [16:0] prev_data  = '0;
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1 && !prev_wr_en) rise_cyc_q.push_back(cyc);
    if (prev_stall && (bus.wr_en !== 1'b1 || bus.wr_addr !== prev_addr || bus.wr_data !== prev_data))
      stab_err++;
    if (bus.wr_en === 1'b1 && bus.wr_ready === 1'b1) begin
      wr_addr_q.push_back(int'(bus.wr_addr));
      wr_data_q.push_back(bus.wr_data);
    end
    if (bus.wr_en === 1'b1 && bus.wr_ready === 1'b0) begin
      stall_addr_q.push_back(int'(bus.wr_addr));
      stall_data_q.push_back(bus.wr_data);
    end
    if (bus.done === 1'b1) done_cyc_q.push_back(cyc);
    prev_wr_en = (bus.wr_en === 1'b1);
    prev_stall = (bus.wr_en === 1'b1) && (bus.wr_ready === 1'b0);
    prev_addr  = bus.wr_addr;
    prev_data  = bus.wr_data;
  end

  int b_wr, b_rise, b_done, b_stall, b_stab;

  function automatic logic [16:0] ref_recip(input int n);
    if (n == 0) return 17'h1FFFF;
    return 17'(65536 / n);
  endfunction

  // Writes after index b that are out of order or carry the wrong reciprocal.
  function automatic int table_errors(input int b);
    int n = 0;
    for (int i = b; i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] != i - b || wr_data_q[i] !== ref_recip(i - b)) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_wr    = wr_addr_q.size();
    b_rise  = rise_cyc_q.size();
    b_done  = done_cyc_q.size();
    b_stall = stall_addr_q.size();
    b_stab  = stab_err;
  endtask

  task automatic start_pulse(output int sc);
    bus.start = 1'b1;
    sc = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
    checks++; if (bus.wr_addr !== 8'd0) begin errors++; $display("FAIL reset_wr_addr got=%0d exp=0", bus.wr_addr); end
    checks++; if (bus.wr_data !== 17'd0) begin errors++; $display("FAIL reset_wr_data got=%0h exp=0", bus.wr_data); end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_full_table();
    int sc, got;
    bit ok;
    int spot_n[6] = '{0, 1, 2, 3, 7, 255};
    int spot_v[6] = '{'h1FFFF, 65536, 32768, 21845, 9362, 257};
    ready_mode = 0;
    snap();
    start_pulse(sc);
    wait_done(6000, ok);
    tick();
    checks++; if (!ok) begin errors++; $display("FAIL full_done_seen got=timeout exp=done"); end
    got = (rise_cyc_q.size() > b_rise) ? rise_cyc_q[b_rise] - sc : -1;
    checks++; if (got !== 19) begin errors++; $display("FAIL full_first_wr_latency got=%0d exp=19", got); end
    got = (done_cyc_q.size() > b_done) ? done_cyc_q[b_done] - sc : -1;
    checks++; if (got !== 4865) begin errors++; $display("FAIL full_done_latency got=%0d exp=4865", got); end
    got = done_cyc_q.size() - b_done;
    checks++; if (got !== 1) begin errors++; $display("FAIL full_done_count got=%0d exp=1", got); end
    got = wr_addr_q.size() - b_wr;
    checks++; if (got !== 256) begin errors++; $display("FAIL full_write_count got=%0d exp=256", got); end
    got = table_errors(b_wr);
    checks++; if (got !== 0) begin errors++; $display("FAIL full_table_mismatches got=%0d exp=0", got); end
    for (int k = 0; k < 6; k++) begin
      got = -1;
      for (int i = b_wr; i < wr_addr_q.size(); i++)
        if (wr_addr_q[i] == spot_n[k]) got = int'(wr_data_q[i]);
      checks++;
      if (got !== spot_v[k]) begin
        errors++; $display("FAIL spot_entry[%0d] got=%0d exp=%0d", spot_n[k], got, spot_v[k]);
      end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL full_busy_after got=%b exp=0", bus.busy); end
  endtask

  task automatic test_backpressure();
    int sc, got, n10;
    bit ok;
    ready_mode = 1;
    stall_addr = 10;
    snap();
    start_pulse(sc);
    wait_done(6000, ok);
    tick();
    ready_mode = 0;
    checks++; if (!ok) begin errors++; $display("FAIL bp_done_seen got=timeout exp=done"); end
    got = (done_cyc_q.size() > b_done) ? done_cyc_q[b_done] - sc : -1;
    checks++; if (got !== 4870) begin errors++; $display("FAIL bp_done_latency got=%0d exp=4870", got); end
    got = stall_addr_q.size() - b_stall;
    checks++; if (got !== 5) begin errors++; $display("FAIL bp_stall_cycles got=%0d exp=5", got); end
    for (int i = b_stall; i < stall_addr_q.size(); i++) begin
      checks++;
      if (stall_addr_q[i] !== 10 || stall_data_q[i] !== ref_recip(10)) begin
        errors++; $display("FAIL bp_hold addr=%0d data=%0d exp addr=10 data=%0d",
                           stall_addr_q[i], stall_data_q[i], ref_recip(10));
      end
    end
    got = stab_err - b_stab;
    checks++; if (got !== 0) begin errors++; $display("FAIL bp_stability_violations got=%0d exp=0", got); end
    n10 = 0;
    for (int i = b_wr; i < wr_addr_q.size(); i++) if (wr_addr_q[i] == 10) n10++;
    checks++; if (n10 !== 1) begin errors++; $display("FAIL bp_entry10_writes got=%0d exp=1", n10); end
    got = wr_addr_q.size() - b_wr;
    checks++; if (got !== 256) begin errors++; $display("FAIL bp_write_count got=%0d exp=256", got); end
    got = table_errors(b_wr);
    checks++; if (got !== 0) begin errors++; $display("FAIL bp_table_mismatches got=%0d exp=0", got); end
  endtask

  task automatic test_start_ignored();
    int sc, got;
    bit ok;
    ready_mode = 0;
    snap();
    start_pulse(sc);
    while (cyc < sc + 100) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(6000, ok);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (40) tick();
    checks++; if (!ok) begin errors++; $display("FAIL ign_done_seen got=timeout exp=done"); end
    got = (done_cyc_q.size() > b_done) ? done_cyc_q[b_done] - sc : -1;
    checks++; if (got !== 4865) begin errors++; $display("FAIL ign_done_latency got=%0d exp=4865", got); end
    got = done_cyc_q.size() - b_done;
    checks++; if (got !== 1) begin errors++; $display("FAIL ign_done_count got=%0d exp=1", got); end
    got = wr_addr_q.size() - b_wr;
    checks++; if (got !== 256) begin errors++; $display("FAIL ign_write_count got=%0d exp=256", got); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_busy_after got=%b exp=0", bus.busy); end
  endtask

  task automatic test_reset_mid_run();
    int sc, got;
    bit ok;
    ready_mode = 0;
    snap();
    start_pulse(sc);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (wr_addr_q.size() - b_wr >= 40) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_entry40 got=timeout exp=40 writes"); end
    repeat (8) tick();
    rst = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en got=%b exp=0", bus.wr_en); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b exp=0", bus.done); end
    rst = 1'b0;
    repeat (30) tick();
    got = wr_addr_q.size() - b_wr;
    checks++; if (got !== 40) begin errors++; $display("FAIL rstmid_writes_before_restart got=%0d exp=40", got); end
    got = done_cyc_q.size() - b_done;
    checks++; if (got !== 0) begin errors++; $display("FAIL rstmid_done_after_rst got=%0d exp=0", got); end
    snap();
    start_pulse(sc);
    wait_done(6000, ok);
    tick();
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_rerun_done got=timeout exp=done"); end
    got = wr_addr_q.size() - b_wr;
    checks++; if (got !== 256) begin errors++; $display("FAIL rstmid_rerun_writes got=%0d exp=256", got); end
    got = table_errors(b_wr);
    checks++; if (got !== 0) begin errors++; $display("FAIL rstmid_rerun_mismatches got=%0d exp=0", got); end
  endtask

  task automatic test_random_ready();
    int sc, got, bad;
    bit ok;
    int cnt[256];
    ready_mode = 2;
    snap();
    start_pulse(sc);
    wait_done(15000, ok);
    tick();
    ready_mode = 0;
    checks++; if (!ok) begin errors++; $display("FAIL rnd_done_seen got=timeout exp=done"); end
    foreach (cnt[i]) cnt[i] = 0;
    for (int i = b_wr; i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] >= 0 && wr_addr_q[i] < 256) cnt[wr_addr_q[i]]++;
    bad = 0;
    foreach (cnt[i]) if (cnt[i] != 1) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL rnd_addr_not_once got=%0d exp=0", bad); end
    got = table_errors(b_wr);
    checks++; if (got !== 0) begin errors++; $display("FAIL rnd_table_mismatches got=%0d exp=0", got); end
    got = done_cyc_q.size() - b_done;
    checks++; if (got !== 1) begin errors++; $display("FAIL rnd_done_count got=%0d exp=1", got); end
    got = stab_err - b_stab;
    checks++; if (got !== 0) begin errors++; $display("FAIL rnd_stability_violations got=%0d exp=0", got); end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    test_reset();
    test_full_table();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_run();
    test_random_ready();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
